// File: rtl/bpu_gshare.sv
// Gshare branch prediction unit: a PHT indexed by PC xor global history, plus a tagged
// direct-mapped BTB for fetch targets. It trains from resolved branches in execute.
module bpu_gshare #(
    parameter int ADDR_W    = 5,
    parameter int GHR_W     = 5,
    parameter int BTB_IDX_W = 3,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_F,
    input  logic              fetch_valid_F,
    output logic              prediction,
    output logic              btb_hit_F,
    output logic [ADDR_W-1:0] target_address_F,
    output logic [GHR_W-1:0]  ghr_F,
    input  logic              update_signal,
    input  logic [ADDR_W-1:0] pc_E,
    input  logic [GHR_W-1:0]  ghr_E,
    input  logic              actual_outcome,
    input  logic [ADDR_W-1:0] target_E,
    input  logic              pred_taken_E,
    input  logic [ADDR_W-1:0] pred_target_E,
    output logic              mispredict_E,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int TAG_W = ADDR_W - BTB_IDX_W;
    localparam int PHT_N = 1 << GHR_W;
    localparam int BTB_N = 1 << BTB_IDX_W;

    logic [1:0]        pht        [PHT_N];
    logic              btb_valid  [BTB_N];
    logic [TAG_W-1:0]  btb_tag    [BTB_N];
    logic [ADDR_W-1:0] btb_target [BTB_N];
    logic [GHR_W-1:0]  ghr;

    logic [GHR_W-1:0]     pht_idx_f;
    logic [BTB_IDX_W-1:0] btb_idx_f;
    logic [TAG_W-1:0]     tag_f;
    logic [GHR_W-1:0]     pht_idx_e;
    logic [BTB_IDX_W-1:0] btb_idx_e;
    logic [1:0]           pht_cur_e;
    logic [1:0]           pht_next_e;

    // Fetch lookup reads pre-edge contents only; same-cycle training shows up next cycle.
    assign pht_idx_f        = pc_F[GHR_W-1:0] ^ ghr;
    assign btb_idx_f        = pc_F[BTB_IDX_W-1:0];
    assign tag_f            = pc_F[ADDR_W-1:BTB_IDX_W];
    assign btb_hit_F        = btb_valid[btb_idx_f] && (btb_tag[btb_idx_f] == tag_f);
    assign prediction       = btb_hit_F && pht[pht_idx_f][1];
    assign target_address_F = prediction ? btb_target[btb_idx_f] : pc_F + ADDR_W'(1);
    assign ghr_F            = ghr;

    assign mispredict_E = update_signal &&
                          ((actual_outcome != pred_taken_E) ||
                           (actual_outcome && pred_taken_E && (target_E != pred_target_E)));

    assign pht_idx_e = pc_E[GHR_W-1:0] ^ ghr_E;
    assign btb_idx_e = pc_E[BTB_IDX_W-1:0];
    assign pht_cur_e = pht[pht_idx_e];

    // NOTE: assign a default first so every path writes pht_next_e and no latch is inferred.
    always_comb begin
        pht_next_e = pht_cur_e;
        if (actual_outcome) begin
            if (pht_cur_e != 2'b11) pht_next_e = pht_cur_e + 2'd1;
        end else begin
            if (pht_cur_e != 2'b00) pht_next_e = pht_cur_e - 2'd1;
        end
    end

    // NOTE: the PHT must start weakly not-taken, so every entry is reset, not just a valid bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
        end else if (update_signal) begin
            pht[pht_idx_e] <= pht_next_e;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
        end else if (update_signal && actual_outcome) begin
            btb_valid[btb_idx_e] <= 1'b1;
        end
    end

    // Tag and target storage need no reset; the valid bit guards them.
    always_ff @(posedge clk) begin
        if (reset && update_signal && actual_outcome) begin
            btb_tag[btb_idx_e]    <= pc_E[ADDR_W-1:BTB_IDX_W];
            btb_target[btb_idx_e] <= target_E;
        end
    end

    // Repair from execute outranks the speculative fetch-side shift.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ghr <= '0;
        end else if (mispredict_E) begin
            ghr <= {ghr_E[GHR_W-2:0], actual_outcome};
        end else if (fetch_valid_F && btb_hit_F) begin
            ghr <= {ghr[GHR_W-2:0], prediction};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (update_signal && (branch_count != '1))
                branch_count <= branch_count + CNT_W'(1);
            if (mispredict_E && (mispredict_count != '1))
                mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bpu_gshare.sv
// Directed bench for bpu_gshare: a table of per-cycle vectors with hand-derived
// expectations, followed by a counter saturation sequence.
module tb_bpu_gshare;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  pc_F;
    logic        fetch_valid_F;
    logic        prediction;
    logic        btb_hit_F;
    logic [4:0]  target_address_F;
    logic [4:0]  ghr_F;
    logic        update_signal;
    logic [4:0]  pc_E;
    logic [4:0]  ghr_E;
    logic        actual_outcome;
    logic [4:0]  target_E;
    logic        pred_taken_E;
    logic [4:0]  pred_target_E;
    logic        mispredict_E;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bpu_gshare dut (
        .clk              (clk),
        .reset            (reset),
        .pc_F             (pc_F),
        .fetch_valid_F    (fetch_valid_F),
        .prediction       (prediction),
        .btb_hit_F        (btb_hit_F),
        .target_address_F (target_address_F),
        .ghr_F            (ghr_F),
        .update_signal    (update_signal),
        .pc_E             (pc_E),
        .ghr_E            (ghr_E),
        .actual_outcome   (actual_outcome),
        .target_E         (target_E),
        .pred_taken_E     (pred_taken_E),
        .pred_target_E    (pred_target_E),
        .mispredict_E     (mispredict_E),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    typedef struct {
        logic       rst;
        logic [4:0] pc_f;
        logic       fv;
        logic       upd;
        logic [4:0] pc_e;
        logic [4:0] ghr_e;
        logic       act;
        logic [4:0] tgt_e;
        logic       ptk;
        logic [4:0] ptgt;
        logic       e_pred;
        logic       e_hit;
        logic [4:0] e_tgt;
        logic [4:0] e_ghr;
        logic       e_misp;
        int         e_b;
        int         e_m;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int rst, input int pcf, input int fv,
                       input int upd, input int pce, input int ghre, input int act,
                       input int tgte, input int ptk, input int ptgt,
                       input int pred, input int hit, input int tgt, input int ghr,
                       input int misp, input int b, input int m);
        vec_t v;
        v.rst = rst[0];     v.pc_f = pcf[4:0];   v.fv = fv[0];
        v.upd = upd[0];     v.pc_e = pce[4:0];   v.ghr_e = ghre[4:0];
        v.act = act[0];     v.tgt_e = tgte[4:0]; v.ptk = ptk[0];
        v.ptgt = ptgt[4:0];
        v.e_pred = pred[0]; v.e_hit = hit[0];    v.e_tgt = tgt[4:0];
        v.e_ghr = ghr[4:0]; v.e_misp = misp[0];  v.e_b = b;  v.e_m = m;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, actual, expected);
        end
    endtask

    task automatic drive(input vec_t v);
        reset          = v.rst;
        pc_F           = v.pc_f;
        fetch_valid_F  = v.fv;
        update_signal  = v.upd;
        pc_E           = v.pc_e;
        ghr_E          = v.ghr_e;
        actual_outcome = v.act;
        target_E       = v.tgt_e;
        pred_taken_E   = v.ptk;
        pred_target_E  = v.ptgt;
    endtask

    initial begin
        vec_t idle;
        //   rst pcF fv upd pcE ghrE act tgtE ptk ptgt | pred hit tgt ghr misp  b  m
        add(1,  4, 1, 0,  0,  0, 0,  0, 0,  0,   0, 0,  5,  0, 0,  0, 0);  // cold lookup
        add(1, 31, 1, 0,  0,  0, 0,  0, 0,  0,   0, 0,  0,  0, 0,  0, 0);  // pc+1 wraps
        add(1,  0, 0, 1,  4,  0, 1, 20, 0,  0,   0, 0,  1,  0, 1,  0, 0);  // taken, predicted NT
        add(1,  4, 1, 0,  0,  0, 0,  0, 0,  0,   0, 1,  5,  1, 0,  1, 1);  // hit, idx 5 weak NT
        add(1,  4, 0, 0,  0,  0, 0,  0, 0,  0,   0, 1,  5,  2, 0,  1, 1);  // spec shift seen
        add(1,  4, 0, 1,  8,  0, 0,  0, 1,  0,   0, 1,  5,  2, 1,  1, 1);  // repair GHR to 0
        add(1,  0, 0, 1,  0,  0, 1,  9, 1,  9,   0, 0,  1,  0, 0,  2, 2);  // taken x5 at idx 0
        add(1,  0, 0, 1,  0,  0, 1,  9, 1,  9,   1, 1,  9,  0, 0,  3, 2);
        add(1,  0, 0, 1,  0,  0, 1,  9, 1,  9,   1, 1,  9,  0, 0,  4, 2);
        add(1,  0, 0, 1,  0,  0, 1,  9, 1,  9,   1, 1,  9,  0, 0,  5, 2);
        add(1,  0, 0, 1,  0,  0, 1,  9, 1,  9,   1, 1,  9,  0, 0,  6, 2);
        add(1,  0, 0, 1,  0,  0, 0,  0, 0,  0,   1, 1,  9,  0, 0,  7, 2);  // not-taken x5
        add(1,  0, 0, 1,  0,  0, 0,  0, 0,  0,   1, 1,  9,  0, 0,  8, 2);
        add(1,  0, 0, 1,  0,  0, 0,  0, 0,  0,   0, 1,  1,  0, 0,  9, 2);
        add(1,  0, 0, 1,  0,  0, 0,  0, 0,  0,   0, 1,  1,  0, 0, 10, 2);
        add(1,  0, 0, 1,  0,  0, 0,  0, 0,  0,   0, 1,  1,  0, 0, 11, 2);
        add(1,  0, 0, 0,  0,  0, 0,  0, 0,  0,   0, 1,  1,  0, 0, 12, 2);  // 00 held, BTB valid
        add(1,  0, 1, 1,  3, 21, 0,  0, 1,  0,   0, 1,  1,  0, 1, 12, 2);  // repair beats shift
        add(1,  0, 0, 0,  0,  0, 0,  0, 0,  0,   0, 1,  1, 10, 0, 13, 3);
        add(1, 12, 1, 1,  4,  0, 1, 20, 1, 20,   0, 0, 13, 10, 0, 13, 3);  // tag mismatch
        add(1, 12, 1, 0,  0,  0, 0,  0, 0,  0,   0, 0, 13, 10, 0, 14, 3);
        add(1,  4, 0, 1,  4,  0, 1, 20, 1,  7,   0, 1,  5, 10, 1, 14, 3);  // wrong target
        add(1,  4, 0, 0,  0,  0, 0,  0, 0,  0,   0, 1,  5,  1, 0, 15, 4);
        add(0,  0, 1, 1,  0,  0, 1,  9, 0,  0,   0, 1,  1,  1, 1, 15, 4);  // reset beats update
        add(1,  0, 0, 0,  0,  0, 0,  0, 0,  0,   0, 0,  1,  0, 0,  0, 0);
        add(1,  4, 1, 0,  0,  0, 0,  0, 0,  0,   0, 0,  5,  0, 0,  0, 0);

        idle = vecs[0];
        idle.rst = 1'b0;
        idle.fv  = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check("prediction",       i, 32'(prediction),       32'(vecs[i].e_pred));
            check("btb_hit_F",        i, 32'(btb_hit_F),        32'(vecs[i].e_hit));
            check("target_address_F", i, 32'(target_address_F), 32'(vecs[i].e_tgt));
            check("ghr_F",            i, 32'(ghr_F),            32'(vecs[i].e_ghr));
            check("mispredict_E",     i, 32'(mispredict_E),     32'(vecs[i].e_misp));
            check("branch_count",     i, 32'(branch_count),     32'(vecs[i].e_b));
            check("mispredict_count", i, 32'(mispredict_count), 32'(vecs[i].e_m));
        end

        // Saturation: 65535 correctly predicted updates, then one more.
        idle = vecs[vecs.size()-1];
        idle.upd = 1'b1;
        idle.fv  = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            drive(idle);
        end
        @(negedge clk);
        #1;
        check("branch_count_max", 0, 32'(branch_count),     32'd65535);
        check("mispredict_zero",  0, 32'(mispredict_count), 32'd0);
        @(negedge clk);
        #1;
        check("branch_count_sat", 0, 32'(branch_count),     32'd65535);
        idle.upd = 1'b0;
        drive(idle);
        @(negedge clk);
        #1;
        check("branch_count_hold", 0, 32'(branch_count),    32'd65535);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
